// File: rtl/des_pkg.sv
// Shared DES constants and the initial-permutation index function.
// Bit numbering is [0:63] with bit 0 as the MSB, i.e. DES numbering minus 1.
package des_pkg;

   localparam int unsigned BLOCK_W = 64;
   localparam int unsigned HALF_W  = 32;

   // Source bit of IP output position i: out[8r+c] = blk[8*(7-c) + s(r)].
   function automatic int unsigned ip_src(input int unsigned i);
      int unsigned r;
      int unsigned c;
      int unsigned s;
      r = i / 8;
      c = i % 8;
      s = (r < 4) ? (2 * r + 1) : (2 * (r - 4));
      return 8 * (7 - c) + s;
   endfunction

endpackage

// File: rtl/des_ip_perm.sv
// Combinational DES initial permutation; pure wiring, same index convention
// as the final-permutation stage.
module des_ip_perm
   import des_pkg::*;
(
   input  logic [BLOCK_W-1:0] blk_i,
   output logic [BLOCK_W-1:0] ip_o
);

   // Index i in [0:63] lives at vector bit 63-i.
   for (genvar i = 0; i < BLOCK_W; i++) begin : g_bit
      localparam int unsigned Src = BLOCK_W - 1 - ip_src(i);
      assign ip_o[BLOCK_W-1-i] = blk_i[Src];
   end

endmodule

// File: rtl/des_ip_loader.sv
// Serial-to-block loader applying DES IP and presenting L0/R0 over valid/ready.
// Optional synchronous abort port enabled by defining DES_IP_ABORT_EN.
module des_ip_loader
   import des_pkg::*;
#(
   parameter int unsigned BEAT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BEAT_W-1:0] in_data,
   input  logic              in_valid,
`ifdef DES_IP_ABORT_EN
   input  logic              abort,
`endif
   output logic              in_ready,
   output logic [HALF_W-1:0] out_l,
   output logic [HALF_W-1:0] out_r,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   localparam int unsigned NBEATS = BLOCK_W / BEAT_W;
   localparam int unsigned CntW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   logic [BLOCK_W-1:0] sreg_q, sreg_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [HALF_W-1:0]  out_l_q, out_l_d;
   logic [HALF_W-1:0]  out_r_q, out_r_d;
   logic               out_valid_q, out_valid_d;

   logic [BLOCK_W-1:0] full_blk;
   logic [BLOCK_W-1:0] ip_blk;
   logic               last_beat;
   logic               accept;
   logic               complete;
   logic               abort_req;

`ifdef DES_IP_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Block as it would stand with the current beat shifted in; also the IP source.
   assign full_blk  = (sreg_q << BEAT_W) | BLOCK_W'(in_data);
   assign last_beat = (cnt_q == CntW'(NBEATS - 1));

   des_ip_perm u_perm (
      .blk_i (full_blk),
      .ip_o  (ip_blk)
   );

   always_comb begin
      // Only the final beat can stall, and only while the held block is not draining.
      in_ready = ~(last_beat & out_valid_q & ~out_ready) & ~abort_req;
      accept   = in_valid & in_ready;
      complete = accept & last_beat;

      sreg_d      = sreg_q;
      cnt_d       = cnt_q;
      out_l_d     = out_l_q;
      out_r_d     = out_r_q;
      out_valid_d = out_valid_q;

      if (abort_req) begin
         sreg_d = '0;
         cnt_d  = '0;
      end else if (accept) begin
         sreg_d = full_blk;
         cnt_d  = last_beat ? '0 : cnt_q + 1'b1;
      end

      if (complete) begin
         out_l_d     = ip_blk[BLOCK_W-1:HALF_W];
         out_r_d     = ip_blk[HALF_W-1:0];
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q      <= '0;
         cnt_q       <= '0;
         out_l_q     <= '0;
         out_r_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         sreg_q      <= sreg_d;
         cnt_q       <= cnt_d;
         out_l_q     <= out_l_d;
         out_r_q     <= out_r_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_l     = out_l_q;
   assign out_r     = out_r_q;
   assign out_valid = out_valid_q;
   assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_des_ip_loader.sv
// Directed self-checking bench for des_ip_loader (BEAT_W=8), using the
// standard DES IP table as the reference; covers abort when DES_IP_ABORT_EN is set.
module tb_des_ip_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_l;
   logic [31:0] out_r;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
`ifdef DES_IP_ABORT_EN
   logic        abort = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   int ip_tab [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                       62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                       57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                       61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   always #5 clk = ~clk;

   des_ip_loader #(.BEAT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
`ifdef DES_IP_ABORT_EN
      .abort     (abort),
`endif
      .in_ready  (in_ready),
      .out_l     (out_l),
      .out_r     (out_r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ip_ref(input logic [63:0] b);
      logic [63:0] o;
      for (int i = 0; i < 64; i++) o[63-i] = b[63-(ip_tab[i]-1)];
      return o;
   endfunction

   function automatic logic [63:0] fp_ref(input logic [63:0] x);
      logic [63:0] o;
      for (int i = 0; i < 64; i++) o[63-(ip_tab[i]-1)] = x[63-i];
      return o;
   endfunction

   // Called #1 after a posedge; returns #1 after the edge that accepted the beat.
   task automatic push(input logic [7:0] d);
      int k;
      k = 0;
      in_valid = 1'b1;
      in_data  = d;
      #1;
      while (!in_ready && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (!in_ready) check("push_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic push_beats(input logic [63:0] b, input int first, input int last);
      for (int k = first; k <= last; k++) push(b[63-8*k -: 8]);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [63:0] blk, blk_b, got;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      #3;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_l", 64'(out_l), 64'd0);
      check("rst_out_r", 64'(out_r), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Known answer
      blk = 64'h0123456789ABCDEF;
      push_beats(blk, 0, 6);
      check("kat_busy_mid", 64'(busy), 64'd1);
      check("kat_valid_early", 64'(out_valid), 64'd0);
      push_beats(blk, 7, 7);
      check("kat_valid", 64'(out_valid), 64'd1);
      check("kat_busy_end", 64'(busy), 64'd0);
      check("kat_l", 64'(out_l), 64'hCC00CCFF);
      check("kat_r", 64'(out_r), 64'hF0AAF0AA);
      idle(1);
      check("kat_drain", 64'(out_valid), 64'd0);

      // Single-bit walk
      for (int p = 0; p < 64; p++) begin
         blk = 64'h8000000000000000 >> p;
         push_beats(blk, 0, 7);
         if (p == 0) check("walk0_r", 64'(out_r), 64'h01000000);
         check($sformatf("walk_%0d", p), {out_l, out_r}, ip_ref(blk));
      end
      idle(1);

      // Backpressure: final beat of block 2 stalls until block 1 drains
      out_ready = 1'b0;
      blk   = 64'h1122334455667788;
      blk_b = 64'hA5A55A5A0F0FF0F0;
      push_beats(blk, 0, 7);
      check("bp_a_valid", 64'(out_valid), 64'd1);
      push_beats(blk_b, 0, 6);
      in_valid = 1'b1;
      in_data  = blk_b[7:0];
      #1;
      check("bp_stall", 64'(in_ready), 64'd0);
      idle(3);
      check("bp_still_stall", 64'(in_ready), 64'd0);
      check("bp_a_held", {out_l, out_r}, ip_ref(blk));
      check("bp_a_valid_held", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      #1;
      check("bp_release", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_b_valid", 64'(out_valid), 64'd1);
      check("bp_b_data", {out_l, out_r}, ip_ref(blk_b));
      idle(1);
      check("bp_b_drain", 64'(out_valid), 64'd0);

      // Round trip through the final permutation
      for (int v = 0; v < 1000; v++) begin
         blk = {$urandom, $urandom};
         push_beats(blk, 0, 7);
         got = fp_ref({out_l, out_r});
         check($sformatf("rt_%0d", v), got, blk);
      end
      idle(1);

      // Reset mid-collection with a block held
      out_ready = 1'b0;
      push_beats(64'hDEADBEEFCAFEF00D, 0, 7);
      push_beats(64'h0011223344556677, 0, 4);
      check("rm_busy_pre", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rm_valid", 64'(out_valid), 64'd0);
      check("rm_busy", 64'(busy), 64'd0);
      check("rm_l", 64'(out_l), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      idle(3);
      check("rm_no_ghost", 64'(out_valid), 64'd0);
      blk = 64'h0123456789ABCDEF;
      push_beats(blk, 0, 7);
      check("rm_fresh_valid", 64'(out_valid), 64'd1);
      check("rm_fresh", {out_l, out_r}, 64'hCC00CCFFF0AAF0AA);
      idle(1);

`ifdef DES_IP_ABORT_EN
      out_ready = 1'b0;
      blk = 64'h13579BDF2468ACE0;
      push_beats(blk, 0, 7);
      push_beats(64'hFFFFFFFFFFFFFFFF, 0, 2);
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      #1;
      check("ab_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      abort    = 1'b0;
      in_valid = 1'b0;
      check("ab_busy", 64'(busy), 64'd0);
      check("ab_valid", 64'(out_valid), 64'd1);
      check("ab_data", {out_l, out_r}, ip_ref(blk));
      out_ready = 1'b1;
      idle(1);
      blk = 64'h0F1E2D3C4B5A6978;
      push_beats(blk, 0, 7);
      check("ab_next", {out_l, out_r}, ip_ref(blk));
      idle(1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/des_ip_loader.md
Name: des_ip_loader

Overview:
- Input-side counterpart of the DES output stage. Accepts a 64-bit block as a serial stream of BEAT_W-bit beats and applies the DES initial permutation (IP).
- Presents the split halves L0/R0 to the round datapath over a valid/ready handshake.
- Double-buffered: the next block can be collected while the current one waits for the consumer.

Parameters:
- BEAT_W, 8, input beat width in bits; legal values 8, 16, 32 and 64; NBEATS = 64/BEAT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  BEAT_W  beat data; first beat maps to block bits [0:BEAT_W-1], bit 0 = MSB.
- in_valid  in  1  beat offered.
- in_ready  out  1  loader can accept the beat.
- out_l  out  32  L0 = IP(block)[0:31].
- out_r  out  32  R0 = IP(block)[32:63].
- out_valid  out  1  L0/R0 held valid.
- out_ready  in  1  round datapath consumes.
- busy  out  1  partial block in collection (beat count != 0).

Behaviour:
- Interface: one clock (clk); reset asynchronous and active-low (rst_n); all state clears immediately on rst_n low.
- Reset values: out_valid=0, out_l=0, out_r=0, busy=0, beat counter=0, shift register=0. in_ready=1 out of reset.
- Bit order: [0:63], bit 0 MSB, DES numbering minus 1.
- Assembly: an accepted beat (in_valid & in_ready) shifts into the shift register MSB-first. The beat counter increments, modulo NBEATS.
- IP mapping: out_block[8r+c] = blk[8*(7-c) + s(r)], with s(r)=2r+1 for r=0..3 and s(r)=2(r-4) for r=4..7. Example: out[0]=blk[57], out[1]=blk[49], out[32]=blk[56], out[63]=blk[6].
- IP is purely combinational from the shift register plus the final beat. It is registered into out_l/out_r on the cycle the last beat is accepted.
- Latency: out_valid rises the cycle after the final beat is accepted.
- Output handshake: out_l/out_r/out_valid hold stable until out_valid & out_ready. On that cycle out_valid drops unless a new block completes in the same cycle.
- in_ready = 0 only when the counter = NBEATS-1 and out_valid=1 and out_ready=0. This stalls only the final beat; non-final beats are always accepted.
- Simultaneous completion and drain (last beat accepted, out_valid & out_ready): the new block loads and out_valid stays 1, giving back-to-back blocks with no bubble.
- BEAT_W=64 (NBEATS=1): every accepted beat completes a block; in_ready = ~out_valid | out_ready.
- Counter wraps to 0 after the final beat; busy follows counter != 0.
- Reset mid-collection or with out_valid high discards all data. No output is produced afterwards for the aborted block.
- in_data is ignored when in_valid=0. No X is propagated into the shift register.

Optional Feature:
- Macro: DES_IP_ABORT_EN.
- Defined: adds input port abort (1 bit, synchronous).
  - abort=1 clears the counter and shift register next edge. A beat presented in the same cycle is dropped and in_ready is forced 0.
  - Output register and out_valid are unaffected.
  - abort has priority over completion of a block in that cycle.
- Undefined: no abort port; a partial block can only be cleared by rst_n.

Decomposition:
- Shared package des_pkg:
  - BLOCK_W=64, HALF_W=32.
  - IP index function/constant array, shared with the final-permutation stage for round-trip checks.
- One sub-module: des_ip_perm, a combinational 64-bit IP wiring with the same index convention as the final-permutation block.
- Counter, shift register and output register stay in des_ip_loader.

Test Plan:
- Known-answer: BEAT_W=8, bytes 01 23 45 67 89 AB CD EF, out_ready=1. Expect out_valid after 8 accepts + 1 cycle, out_l=CC00CCFF, out_r=F0AAF0AA.
- Single-bit walk: block 8000000000000000 (blk[0]=1). Expect only out bit 39 set, out_r=01000000; repeat for all 64 positions against the table.
- Backpressure: out_ready=0 with a second block streaming.
  - Expect in_ready low only at the 8th beat of block 2 and block-1 outputs stable.
  - Release out_ready: block 2 appears the next cycle with no gap.
- Round-trip: random blocks through des_ip_loader, then the final-permutation block on {out_l,out_r}. Expect the original block, 1000 vectors.
- Reset mid-operation: assert rst_n low after beat 5. Expect out_valid=0, busy=0 immediately; then a fresh 8-beat block yields the correct IP only.
- DES_IP_ABORT_EN: abort after beat 3 while out_valid=1. Expect out_valid/data retained, busy=0, and the next 8 beats form a correct block.
